vector_feeder: RTL and testbench
================================

VECTOR_FEEDER -- requirements
Module: vector_feeder

Interface
REQ-001 Parameters (name, default, meaning), SHALL be: NROW, 16, weight rows per column; NCOL, 16, vector length and weight columns; QN, 6, integer bits; QM, 11, fraction bits.
REQ-002 Derived widths SHALL be: BITWIDTH=QN+QM+1 (18); ADDR_BITWIDTH=log2(NCOL) (4); LAYER_BITWIDTH=BITWIDTH*NROW (288).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 colAddress  in  ADDR_BITWIDTH  column index driven by the dot-product engine.
REQ-006 dataReady  in  1  one-cycle end-of-pass pulse from the dot-product engine.
REQ-007 weightRow  out  LAYER_BITWIDTH  weight column colAddress; element r at bits [r*BITWIDTH +: BITWIDTH].
REQ-008 inputVector  out  BITWIDTH  element colAddress of the active vector bank, signed Q(QN.QM).
REQ-009 vecIn  in  BITWIDTH  next-vector element stream, element 0 first.
REQ-010 vecValid  in  1  vecIn valid.
REQ-011 vecReady  out  1  feeder can accept vecIn.
REQ-012 wgtWrEn, wgtWrAddr, wgtWrData  in  1 / ADDR_BITWIDTH / LAYER_BITWIDTH  weight column write port.
REQ-013 bankValid  out  1  active bank holds a complete vector.
REQ-014 overrun  out  1  one-cycle pulse: pass ended before the next vector was complete.

Function
REQ-015 Storage SHALL be: weight memory of NCOL x LAYER_BITWIDTH; two vector banks (active, shadow) of NCOL x BITWIDTH; bank-select flag.
REQ-016 weightRow and inputVector SHALL be combinational reads (zero latency) of weight memory and active bank at colAddress.
REQ-017 For colAddress >= NCOL, weightRow and inputVector SHALL be zero.
REQ-018 Weight write SHALL occur at clk edge when wgtWrEn=1; a read of the same address in that cycle returns old data, new data from next cycle.
REQ-019 Load FSM states SHALL be LOAD and FULL; reset state LOAD with load counter 0.
REQ-020 In LOAD, vecReady=1; on vecValid&vecReady write vecIn to shadow[counter], increment counter; accepting element NCOL-1 -> counter wraps to 0, state FULL.
REQ-021 In FULL, vecReady=0; no element accepted; vecIn ignored.
REQ-022 Swap SHALL occur at an edge where state=FULL and (dataReady=1 or bankValid=0): bank-select toggles, bankValid<=1, state<=LOAD.
REQ-023 Swap SHALL take effect for reads in the cycle after the edge; new shadow is the former active bank, overwritten by subsequent loads.
REQ-024 dataReady=1 while state=LOAD SHALL pulse overrun for one cycle; active bank unchanged and reused for the next pass.
REQ-025 Last element accepted in the same cycle as dataReady: FULL not yet registered, so overrun pulses, state enters FULL, swap waits for next dataReady.
REQ-026 dataReady with bankValid=0 and state LOAD SHALL pulse overrun.
REQ-027 Weight writes SHALL be independent of the load FSM and allowed in every state.

Reset
REQ-028 On reset assertion, immediately and without clk: state LOAD, counter 0, bank-select 0, bankValid 0, overrun 0, vecReady 1, all weight and bank entries 0, hence weightRow=0 and inputVector=0.
REQ-029 Reset mid-load SHALL discard the partial vector; first element after release is stored at index 0.

Verification
REQ-030 Reset, then stream 16 elements 1..16 (Q: value<<11) with vecValid held -> vecReady low after the 16th, swap next edge, bankValid=1, colAddress=5 gives inputVector=6<<11.
REQ-031 Write column 3 with all rows 0x00800 -> weightRow at colAddress=3 reads 16 copies of 0x00800 the cycle after write, old value during the write cycle.
REQ-032 Active bank valid, shadow full with 100..115, pulse dataReady -> reads switch to 100.. next cycle, vecReady=1, overrun=0.
REQ-033 Shadow holds 7 elements, pulse dataReady -> overrun one cycle, inputVector unchanged, loading continues at index 7.
REQ-034 Assert reset asynchronously after 9 elements loaded -> outputs zero before next edge; reload 16 elements -> index 0 holds first new element.
REQ-035 colAddress=15 after full load returns element 16; vecValid toggling randomly -> every accepted element stored in order, none lost or duplicated.

Source files
------------

// File: rtl/vector_feeder.sv
// Feeds one weight column and one vector element per colAddress to a dot-product engine from a double-buffered vector store.
// Reads are combinational (zero latency); vecReady drops while the shadow bank is full and rises again after the bank swap.
module vector_feeder #(
    parameter  int NROW           = 16,
    parameter  int NCOL           = 16,
    parameter  int QN             = 6,
    parameter  int QM             = 11,
    localparam int BITWIDTH       = QN + QM + 1,
    localparam int ADDR_BITWIDTH  = $clog2(NCOL),
    localparam int LAYER_BITWIDTH = BITWIDTH * NROW
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [ADDR_BITWIDTH-1:0]  colAddress,
    input  logic                      dataReady,
    output logic [LAYER_BITWIDTH-1:0] weightRow,
    output logic [BITWIDTH-1:0]       inputVector,
    input  logic [BITWIDTH-1:0]       vecIn,
    input  logic                      vecValid,
    output logic                      vecReady,
    input  logic                      wgtWrEn,
    input  logic [ADDR_BITWIDTH-1:0]  wgtWrAddr,
    input  logic [LAYER_BITWIDTH-1:0] wgtWrData,
    output logic                      bankValid,
    output logic                      overrun
);

    typedef enum logic {
        LOAD = 1'b0,
        FULL = 1'b1
    } state_t;

    localparam logic [ADDR_BITWIDTH-1:0] LAST_IDX = ADDR_BITWIDTH'(NCOL - 1);
    localparam logic [ADDR_BITWIDTH:0]   NCOL_W   = (ADDR_BITWIDTH + 1)'(NCOL);

    state_t                     state;
    state_t                     state_next;
    logic [ADDR_BITWIDTH-1:0]   count;
    logic [ADDR_BITWIDTH-1:0]   count_next;
    logic                       bank_sel;
    logic                       accept;
    logic                       swap;
    logic                       rd_in_range;
    logic                       wr_in_range;

    logic [BITWIDTH-1:0]        bank [2][NCOL];
    logic [LAYER_BITWIDTH-1:0]  wmem [NCOL];

    // Load FSM: LOAD fills the shadow bank, FULL waits for the engine to finish its pass.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= LOAD;
            count <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    always_comb begin
        state_next = state;
        count_next = count;
        vecReady   = 1'b0;
        accept     = 1'b0;
        swap       = 1'b0;
        case (state)
            LOAD: begin
                vecReady = 1'b1;
                if (vecValid) begin
                    accept = 1'b1;
                    if (count == LAST_IDX) begin
                        count_next = '0;
                        state_next = FULL;
                    end else begin
                        count_next = count + 1'b1;
                    end
                end
            end
            FULL: begin
                // With no valid active bank there is no pass to wait for.
                if (dataReady || !bankValid) begin
                    swap       = 1'b1;
                    state_next = LOAD;
                end
            end
            default: state_next = LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bank_sel  <= 1'b0;
            bankValid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (swap) begin
                bank_sel  <= ~bank_sel;
                bankValid <= 1'b1;
            end
            // A pass ending while still loading means the engine reuses the old vector.
            overrun <= dataReady && (state == LOAD);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int b = 0; b < 2; b++) begin
                for (int c = 0; c < NCOL; c++) begin
                    bank[b][c] <= '0;
                end
            end
        end else if (accept) begin
            bank[~bank_sel][count] <= vecIn;
        end
    end

    assign wr_in_range = {1'b0, wgtWrAddr} < NCOL_W;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < NCOL; c++) begin
                wmem[c] <= '0;
            end
        end else if (wgtWrEn && wr_in_range) begin
            wmem[wgtWrAddr] <= wgtWrData;
        end
    end

    assign rd_in_range = {1'b0, colAddress} < NCOL_W;

    always_comb begin
        weightRow   = '0;
        inputVector = '0;
        if (rd_in_range) begin
            weightRow   = wmem[colAddress];
            inputVector = bank[bank_sel][colAddress];
        end
    end

endmodule

// File: tb/tb_vector_feeder.sv
// Directed and random stimulus for vector_feeder against a queue-based model of the double-buffered vector store.
module tb_vector_feeder;

    localparam int NROW = 16;
    localparam int NCOL = 16;
    localparam int BW   = 18;
    localparam int AW   = 4;
    localparam int LW   = BW * NROW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] colAddress = '0;
    logic          dataReady = 1'b0;
    logic [LW-1:0] weightRow;
    logic [BW-1:0] inputVector;
    logic [BW-1:0] vecIn = '0;
    logic          vecValid = 1'b0;
    logic          vecReady;
    logic          wgtWrEn = 1'b0;
    logic [AW-1:0] wgtWrAddr = '0;
    logic [LW-1:0] wgtWrData = '0;
    logic          bankValid;
    logic          overrun;

    vector_feeder dut (
        .clk        (clk),
        .reset      (reset),
        .colAddress (colAddress),
        .dataReady  (dataReady),
        .weightRow  (weightRow),
        .inputVector(inputVector),
        .vecIn      (vecIn),
        .vecValid   (vecValid),
        .vecReady   (vecReady),
        .wgtWrEn    (wgtWrEn),
        .wgtWrAddr  (wgtWrAddr),
        .wgtWrData  (wgtWrData),
        .bankValid  (bankValid),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    // Model: the vector the engine sees, the elements collected so far for the next one.
    logic [BW-1:0] m_active [NCOL];
    logic [BW-1:0] m_shadow [$];
    logic [LW-1:0] m_w [NCOL];
    logic          m_bv;
    logic          m_ovr;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NCOL; i++) begin
            m_active[i] = '0;
            m_w[i]      = '0;
        end
        m_shadow.delete();
        m_bv  = 1'b0;
        m_ovr = 1'b0;
    endtask

    task automatic check_all(input string tag);
        #1;
        chk({tag, ".vecReady"},    LW'(vecReady),    LW'(m_shadow.size() < NCOL));
        chk({tag, ".bankValid"},   LW'(bankValid),   LW'(m_bv));
        chk({tag, ".overrun"},     LW'(overrun),     LW'(m_ovr));
        chk({tag, ".inputVector"}, LW'(inputVector), LW'(m_active[colAddress]));
        chk({tag, ".weightRow"},   weightRow,        m_w[colAddress]);
    endtask

    task automatic cycle(input string tag);
        bit ready;
        bit acc;
        bit swp;
        check_all(tag);
        ready = m_shadow.size() < NCOL;
        acc   = ready && vecValid;
        swp   = !ready && (dataReady || !m_bv);
        @(posedge clk);
        if (!reset) begin
            m_ovr = dataReady && ready;
            if (wgtWrEn) m_w[wgtWrAddr] = wgtWrData;
            if (acc) begin
                m_shadow.push_back(vecIn);
            end else if (swp) begin
                for (int i = 0; i < NCOL; i++) m_active[i] = m_shadow[i];
                m_shadow.delete();
                m_bv = 1'b1;
            end
        end
        #1;
    endtask

    task automatic load(input string tag, input int n, input int base);
        vecValid = 1'b1;
        for (int i = 0; i < n; i++) begin
            vecIn = BW'(base + i);
            cycle(tag);
        end
        vecValid = 1'b0;
    endtask

    initial begin
        model_reset();
        #2;
        check_all("reset");
        cycle("reset_hold");
        reset = 1'b0;

        // Stream 1..16 in Q format with vecValid held, then the automatic first swap.
        vecValid = 1'b1;
        for (int i = 0; i < NCOL; i++) begin
            vecIn = BW'((i + 1) << 11);
            cycle("load_q");
        end
        vecValid = 1'b0;
        #1;
        chk("first_full_ready_low", LW'(vecReady), LW'(0));
        cycle("first_swap");
        colAddress = 4'd5;
        #1;
        chk("first_elem5", LW'(inputVector), LW'(6 << 11));
        chk("first_bank_valid", LW'(bankValid), LW'(1));
        colAddress = 4'd15;
        #1;
        chk("first_elem15", LW'(inputVector), LW'(16 << 11));

        // Weight column write: old data in the write cycle, new data afterwards.
        wgtWrEn    = 1'b1;
        wgtWrAddr  = 4'd3;
        wgtWrData  = {NROW{18'h00800}};
        colAddress = 4'd3;
        #1;
        chk("wr_old", weightRow, LW'(0));
        cycle("wr");
        wgtWrEn = 1'b0;
        #1;
        chk("wr_new", weightRow, {NROW{18'h00800}});

        // Full shadow of 100..115 swapped in by a dataReady pulse.
        load("load100", NCOL, 100);
        colAddress = 4'd0;
        cycle("full_idle");
        cycle("full_idle");
        dataReady = 1'b1;
        cycle("swap100");
        dataReady = 1'b0;
        #1;
        chk("swap100_elem0", LW'(inputVector), LW'(100));
        chk("swap100_ready", LW'(vecReady), LW'(1));
        chk("swap100_no_ovr", LW'(overrun), LW'(0));

        // Partial shadow: overrun, active vector kept, loading resumes at index 7.
        load("load200a", 7, 200);
        dataReady = 1'b1;
        cycle("ovr7");
        dataReady = 1'b0;
        #1;
        chk("ovr7_pulse", LW'(overrun), LW'(1));
        chk("ovr7_keep", LW'(inputVector), LW'(100));
        cycle("ovr7_after");
        #1;
        chk("ovr7_one_cycle", LW'(overrun), LW'(0));
        load("load200b", NCOL - 7, 207);
        dataReady = 1'b1;
        cycle("swap200");
        dataReady = 1'b0;
        colAddress = 4'd7;
        #1;
        chk("swap200_elem7", LW'(inputVector), LW'(207));
        colAddress = 4'd0;
        #1;
        chk("swap200_elem0", LW'(inputVector), LW'(200));

        // Last element accepted together with dataReady: overrun, and the swap waits.
        load("load400a", NCOL - 1, 400);
        vecValid  = 1'b1;
        vecIn     = BW'(415);
        dataReady = 1'b1;
        cycle("last_with_dr");
        vecValid  = 1'b0;
        dataReady = 1'b0;
        #1;
        chk("last_dr_ovr", LW'(overrun), LW'(1));
        chk("last_dr_full", LW'(vecReady), LW'(0));
        chk("last_dr_keep", LW'(inputVector), LW'(200));
        cycle("last_dr_wait");
        dataReady = 1'b1;
        cycle("last_dr_swap");
        dataReady = 1'b0;
        #1;
        chk("last_dr_new", LW'(inputVector), LW'(400));

        // Asynchronous reset in the middle of a load.
        load("load_partial", 9, 500);
        colAddress = 4'd3;
        #2;
        reset = 1'b1;
        #1;
        chk("arst_vec", LW'(inputVector), LW'(0));
        chk("arst_wgt", weightRow, LW'(0));
        chk("arst_bv", LW'(bankValid), LW'(0));
        chk("arst_ready", LW'(vecReady), LW'(1));
        model_reset();
        cycle("arst_hold");
        reset = 1'b0;
        load("reload", NCOL, 300);
        cycle("reload_swap");
        colAddress = 4'd0;
        #1;
        chk("reload_elem0", LW'(inputVector), LW'(300));
        colAddress = 4'd15;
        #1;
        chk("reload_elem15", LW'(inputVector), LW'(315));

        // Random traffic on every input, checked each cycle against the model.
        for (int t = 0; t < 800; t++) begin
            vecValid   = 1'($urandom_range(0, 1));
            vecIn      = BW'($urandom);
            dataReady  = ($urandom_range(0, 9) == 0);
            colAddress = AW'($urandom);
            wgtWrEn    = ($urandom_range(0, 3) == 0);
            wgtWrAddr  = AW'($urandom);
            wgtWrData  = {$urandom, $urandom, $urandom, $urandom, $urandom,
                          $urandom, $urandom, $urandom, $urandom};
            cycle("rand");
        end
        vecValid  = 1'b0;
        dataReady = 1'b0;
        wgtWrEn   = 1'b0;
        cycle("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
